// File: rtl/switch_debouncer.sv
// rtl/switch_debouncer.sv - 2-FF synchronizer plus per-bit debounce counters for the DIP-switch bank.
// Optional macro SW_ACTIVE_LOW_EN: inverts sw_raw so a closed pulled-up switch reads as 1.
module switch_debouncer #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int CNT_W           = 18
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_db,
  output logic             sw_changed,
  output logic             stable
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] in_n;
  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] accept;
  logic [WIDTH-1:0] cnt_busy;
  logic [CNT_W-1:0] cnt [WIDTH];

`ifdef SW_ACTIVE_LOW_EN
  assign in_n = ~sw_raw;
`else
  assign in_n = sw_raw;
`endif

  always_comb begin
    accept   = '0;
    cnt_busy = '0;
    for (int i = 0; i < WIDTH; i++) begin
      accept[i]   = (sync2[i] != sw_db[i]) && (cnt[i] == TERM);
      cnt_busy[i] = (cnt[i] != '0);
    end
  end

  // A counter can still be nonzero for one cycle after a bounce back to the old level.
  assign stable = (sync2 == sw_db) && (cnt_busy == '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1      <= '0;
      sync2      <= '0;
      sw_db      <= '0;
      sw_changed <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1      <= in_n;
      sync2      <= sync1;
      sw_changed <= |accept;
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2[i] == sw_db[i]) begin
          cnt[i] <= '0;
        end else if (accept[i]) begin
          sw_db[i] <= sync2[i];
          cnt[i]   <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// tb/tb_switch_debouncer.sv - directed self-checking bench for switch_debouncer (DEBOUNCE_CYCLES=8).
module tb_switch_debouncer;

`ifdef SW_ACTIVE_LOW_EN
  localparam logic [3:0] INV = 4'b1111;
`else
  localparam logic [3:0] INV = 4'b0000;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] sw_raw = 4'b0000;
  logic [3:0] sw_db;
  logic       sw_changed;
  logic       stable;

  int vectors = 0;
  int miscompares = 0;

  switch_debouncer #(.WIDTH(4), .DEBOUNCE_CYCLES(8), .CNT_W(4)) dut (
    .clk(clk),
    .reset(reset),
    .sw_raw(sw_raw),
    .sw_db(sw_db),
    .sw_changed(sw_changed),
    .stable(stable)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the logical switch level; the pin level depends on the board polarity.
  task automatic drive(input logic [3:0] v);
    sw_raw = v ^ INV;
  endtask

  task automatic reset_dut();
    drive(4'b0000);
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset();
    reset  = 1'b0;
    sw_raw = 4'b1010;
    for (int e = 0; e < 3; e++) begin
      tick();
      vectors++;
      if (sw_db !== 4'b0000) begin
        miscompares++;
        $display("FAIL reset_sw_db cycle %0d: got %b want 0000", e, sw_db);
      end
      vectors++;
      if (sw_changed !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_sw_changed cycle %0d: got %b want 0", e, sw_changed);
      end
      vectors++;
      if (stable !== 1'b1) begin
        miscompares++;
        $display("FAIL reset_stable cycle %0d: got %b want 1", e, stable);
      end
    end
  endtask

  task automatic test_latency();
    logic [3:0] exp_db;
    reset_dut();
    drive(4'b0101);
    for (int e = 0; e <= 12; e++) begin
      tick();
      exp_db = (e >= 9) ? 4'b0101 : 4'b0000;
      vectors++;
      if (sw_db !== exp_db) begin
        miscompares++;
        $display("FAIL latency_sw_db edge %0d: got %b want %b", e, sw_db, exp_db);
      end
      vectors++;
      if (sw_changed !== (e == 9)) begin
        miscompares++;
        $display("FAIL latency_sw_changed edge %0d: got %b want %b", e, sw_changed, (e == 9));
      end
      vectors++;
      if (stable !== !(e >= 1 && e < 9)) begin
        miscompares++;
        $display("FAIL latency_stable edge %0d: got %b want %b", e, stable, !(e >= 1 && e < 9));
      end
    end
  endtask

  task automatic test_glitch();
    reset_dut();
    drive(4'b0001);
    for (int e = 0; e < 16; e++) begin
      tick();
      if (e == 4) drive(4'b0000);
      vectors++;
      if (sw_db !== 4'b0000) begin
        miscompares++;
        $display("FAIL glitch_sw_db edge %0d: got %b want 0000", e, sw_db);
      end
      vectors++;
      if (sw_changed !== 1'b0) begin
        miscompares++;
        $display("FAIL glitch_sw_changed edge %0d: got %b want 0", e, sw_changed);
      end
    end
  endtask

  task automatic test_independent_bits();
    logic [3:0] exp_db;
    reset_dut();
    drive(4'b1000);
    for (int e = 0; e <= 14; e++) begin
      tick();
      if (e == 2) drive(4'b1010);
      exp_db = (e >= 12) ? 4'b1010 : (e >= 9) ? 4'b1000 : 4'b0000;
      vectors++;
      if (sw_db !== exp_db) begin
        miscompares++;
        $display("FAIL indep_sw_db edge %0d: got %b want %b", e, sw_db, exp_db);
      end
      vectors++;
      if (sw_changed !== (e == 9 || e == 12)) begin
        miscompares++;
        $display("FAIL indep_sw_changed edge %0d: got %b want %b", e, sw_changed, (e == 9 || e == 12));
      end
    end
  endtask

  task automatic test_reset_mid_count();
    logic [3:0] exp_db;
    reset_dut();
    drive(4'b1111);
    for (int e = 0; e < 5; e++) begin
      tick();
      vectors++;
      if (sw_db !== 4'b0000) begin
        miscompares++;
        $display("FAIL midreset_pre_sw_db edge %0d: got %b want 0000", e, sw_db);
      end
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    vectors++;
    if (sw_db !== 4'b0000 || sw_changed !== 1'b0 || stable !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_after: got db=%b chg=%b stable=%b want db=0000 chg=0 stable=1",
               sw_db, sw_changed, stable);
    end
    for (int r = 0; r <= 11; r++) begin
      tick();
      exp_db = (r >= 9) ? 4'b1111 : 4'b0000;
      vectors++;
      if (sw_db !== exp_db) begin
        miscompares++;
        $display("FAIL midreset_requal_sw_db edge %0d: got %b want %b", r, sw_db, exp_db);
      end
      vectors++;
      if (sw_changed !== (r == 9)) begin
        miscompares++;
        $display("FAIL midreset_requal_sw_changed edge %0d: got %b want %b", r, sw_changed, (r == 9));
      end
    end
  endtask

  task automatic test_toggle();
    reset_dut();
    for (int e = 0; e < 24; e++) begin
      drive((e % 2 == 0) ? 4'b1111 : 4'b0000);
      tick();
      vectors++;
      if (sw_db !== 4'b0000 || sw_changed !== 1'b0) begin
        miscompares++;
        $display("FAIL toggle edge %0d: got db=%b chg=%b want db=0000 chg=0", e, sw_db, sw_changed);
      end
    end
  endtask

  // Raw pin levels are given explicitly here so the polarity inversion itself is checked.
  task automatic test_polarity();
    logic [3:0] exp_db;
    reset_dut();
    sw_raw = INV;
    for (int e = 0; e < 12; e++) begin
      tick();
      vectors++;
      if (sw_db !== 4'b0000 || sw_changed !== 1'b0) begin
        miscompares++;
        $display("FAIL polarity_idle edge %0d: got db=%b chg=%b want db=0000 chg=0", e, sw_db, sw_changed);
      end
    end
    sw_raw = INV ^ 4'b0001;
    for (int e = 0; e <= 11; e++) begin
      tick();
      exp_db = (e >= 9) ? 4'b0001 : 4'b0000;
      vectors++;
      if (sw_db !== exp_db) begin
        miscompares++;
        $display("FAIL polarity_sw_db edge %0d: got %b want %b", e, sw_db, exp_db);
      end
      vectors++;
      if (sw_changed !== (e == 9)) begin
        miscompares++;
        $display("FAIL polarity_sw_changed edge %0d: got %b want %b", e, sw_changed, (e == 9));
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_independent_bits();
    test_reset_mid_count();
    test_toggle();
    test_polarity();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
